multicycle_control_unit: RTL and testbench

- Moore/Mealy FSM controller for the multicycle MIPS datapath.
- Successor to the single-cycle decoder: same ISA (ADD, SUB, AND, OR, NOR, SLT, XOR, ADDI, ANDI, ORI, XORI, LW, SW, BEQ, BNE, J) and the same ULAControl encoding.
- Instructions are sequenced over 3-5 states, with a memory ready handshake and a retired-instruction counter.
- Sits between the instruction register (OP, Funct) and the shared-memory multicycle datapath.

---
 rtl/multicycle_control_unit_if.sv | 37 +++
 rtl/multicycle_control_unit.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Instruction-register / datapath bundle for the multicycle controller.
// master = controller side, slave = datapath side.
interface multicycle_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       OP;
    logic [5:0]       Funct;
    logic             Zero;
    logic             mem_ready;
    logic             mem_req;
    logic             MemWrite;
    logic             IorD;
    logic             IRWrite;
    logic             PCEn;
    logic [1:0]       PCSrc;
    logic             ULASrcA;
    logic [1:0]       ULASrcB;
    logic [2:0]       ULAControl;
    logic             RegWrite;
    logic             RegDst;
    logic             MemtoReg;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;
    logic             illegal;

    modport master (
        input  OP, Funct, Zero, mem_ready,
        output mem_req, MemWrite, IorD, IRWrite, PCEn, PCSrc, ULASrcA, ULASrcB,
               ULAControl, RegWrite, RegDst, MemtoReg, state, instr_count, illegal
    );

    modport slave (
        output OP, Funct, Zero, mem_ready,
        input  mem_req, MemWrite, IorD, IRWrite, PCEn, PCSrc, ULASrcA, ULASrcB,
               ULAControl, RegWrite, RegDst, MemtoReg, state, instr_count, illegal
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller FSM with memory-ready handshake and retire counter.
// Define ILLEGAL_TRAP_EN to park in TRAP on an unsupported OP/Funct instead of NOP-ing it.
module multicycle_control_unit #(
    parameter int CNT_W     = 16,
    parameter bit ZERO_WAIT = 1'b0
) (
    input logic                        clk,
    input logic                        rst_n,
    multicycle_control_unit_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        IMMEXEC  = 4'd8,
        IMMWB    = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12
    } state_t;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = TRAP;
`else
    localparam state_t ILL_NEXT = FETCH;
`endif

    state_t           st, nx;
    logic             rdy;
    logic             retire;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt;

    assign rdy             = bus.mem_ready | ZERO_WAIT;
    assign bus.state       = st;
    assign bus.instr_count = cnt;
    assign bus.illegal     = illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= FETCH;
            cnt       <= '0;
            illegal_q <= 1'b0;
        end else begin
            st        <= nx;
            illegal_q <= illegal_d;
            if (retire) cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        nx             = st;
        retire         = 1'b0;
        illegal_d      = 1'b0;
        bus.mem_req    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IorD       = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.PCEn       = 1'b0;
        bus.PCSrc      = 2'b00;
        bus.ULASrcA    = 1'b0;
        bus.ULASrcB    = 2'b00;
        bus.ULAControl = 3'b000;
        bus.RegWrite   = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        case (st)
            FETCH: begin
                bus.mem_req    = 1'b1;
                bus.ULASrcB    = 2'b01;
                bus.ULAControl = 3'b010;
                bus.IRWrite    = rdy;
                bus.PCEn       = rdy;
                if (rdy) nx = DECODE;
            end
            DECODE: begin
                // Speculatively compute the branch target while the opcode decodes
                bus.ULASrcB    = 2'b11;
                bus.ULAControl = 3'b010;
                case (bus.OP)
                    6'b000000:                                   nx = EXECUTE;
                    6'b100011, 6'b101011:                        nx = MEMADR;
                    6'b001000, 6'b001100, 6'b001101, 6'b001110:  nx = IMMEXEC;
                    6'b000100, 6'b000101:                        nx = BRANCH;
                    6'b000010:                                   nx = JUMP;
                    default: begin
                        nx        = ILL_NEXT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.ULASrcA    = 1'b1;
                bus.ULASrcB    = 2'b10;
                bus.ULAControl = 3'b010;
                nx = (bus.OP == 6'b101011) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.IorD    = 1'b1;
                if (rdy) nx = MEMWB;
            end
            MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                nx     = FETCH;
                retire = 1'b1;
            end
            MEMWRITE: begin
                bus.mem_req  = 1'b1;
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (rdy) begin
                    nx     = FETCH;
                    retire = 1'b1;
                end
            end
            EXECUTE: begin
                bus.ULASrcA = 1'b1;
                nx = ALUWB;
                case (bus.Funct)
                    6'b100000: bus.ULAControl = 3'b010;
                    6'b100010: bus.ULAControl = 3'b110;
                    6'b100100: bus.ULAControl = 3'b000;
                    6'b100101: bus.ULAControl = 3'b001;
                    6'b100111: bus.ULAControl = 3'b011;
                    6'b101010: bus.ULAControl = 3'b111;
                    6'b100110: bus.ULAControl = 3'b100;
                    default: begin
                        nx        = ILL_NEXT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                nx     = FETCH;
                retire = 1'b1;
            end
            IMMEXEC: begin
                bus.ULASrcA = 1'b1;
                bus.ULASrcB = 2'b10;
                case (bus.OP)
                    6'b001000: bus.ULAControl = 3'b010;
                    6'b001100: bus.ULAControl = 3'b000;
                    6'b001101: bus.ULAControl = 3'b001;
                    6'b001110: bus.ULAControl = 3'b100;
                    default:   bus.ULAControl = 3'b000;
                endcase
                nx = IMMWB;
            end
            IMMWB: begin
                bus.RegWrite = 1'b1;
                nx     = FETCH;
                retire = 1'b1;
            end
            BRANCH: begin
                bus.ULASrcA    = 1'b1;
                bus.ULAControl = 3'b110;
                bus.PCSrc      = 2'b01;
                bus.PCEn       = (bus.OP == 6'b000101) ? !bus.Zero : bus.Zero;
                nx     = FETCH;
                retire = 1'b1;
            end
            JUMP: begin
                bus.PCSrc = 2'b10;
                bus.PCEn  = 1'b1;
                nx     = FETCH;
                retire = 1'b1;
            end
            TRAP: begin
                // Only reset leaves this state; keep the flag raised meanwhile
                nx        = TRAP;
                illegal_d = 1'b1;
            end
            default: nx = FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle vector table plus
// reset-abort and counter-wrap sequences.
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       zero, rdy;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.CNT_W(16)) b1();
    multicycle_control_unit_if #(.CNT_W(4))  b2();

    assign b1.OP = op;  assign b1.Funct = funct;  assign b1.Zero = zero;  assign b1.mem_ready = rdy;
    assign b2.OP = op;  assign b2.Funct = funct;  assign b2.Zero = zero;  assign b2.mem_ready = rdy;

    multicycle_control_unit #(.CNT_W(16), .ZERO_WAIT(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    multicycle_control_unit #(.CNT_W(4),  .ZERO_WAIT(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    typedef struct packed {
        logic [3:0] st;
        logic       req, mw, iord, irw, pcen;
        logic [1:0] pcsrc;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] ctl;
        logic       rw, rd, m2r, ill;
    } out_t;

    typedef struct {
        logic [5:0] op, funct;
        logic       zero, rdy;
        out_t       exp;
        int         cnt;
    } vec_t;

    out_t a1;
    assign a1 = {b1.state, b1.mem_req, b1.MemWrite, b1.IorD, b1.IRWrite, b1.PCEn, b1.PCSrc,
                 b1.ULASrcA, b1.ULASrcB, b1.ULAControl, b1.RegWrite, b1.RegDst, b1.MemtoReg,
                 b1.illegal};

    //                           st     req   mw    iord  irw   pcen  pcsrc  srca  srcb   ctl     rw    rd    m2r   ill
    localparam out_t E_FETCH  = {4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_FETCHW = {4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_DEC    = {4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_MADR   = {4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_MRD    = {4'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_MWB    = {4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam out_t E_MWR    = {4'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_EXEC0  = {4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_ALUWB  = {4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam out_t E_IMM0   = {4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_IMMWB  = {4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam out_t E_BR0    = {4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_JUMP   = {4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam out_t E_TRAP   = {4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};

    function automatic out_t ex(input logic [2:0] c);
        out_t o = E_EXEC0;
        o.ctl = c;
        return o;
    endfunction

    function automatic out_t im(input logic [2:0] c);
        out_t o = E_IMM0;
        o.ctl = c;
        return o;
    endfunction

    function automatic out_t br(input logic p);
        out_t o = E_BR0;
        o.pcen = p;
        return o;
    endfunction

    function automatic out_t ill(input out_t i);
        out_t o = i;
        o.ill = 1'b1;
        return o;
    endfunction

    vec_t tv[$];

    task automatic add(input logic [5:0] o_, input logic [5:0] f_, input logic z_, input logic r_,
                       input out_t e_, input int c_);
        vec_t v;
        v.op = o_; v.funct = f_; v.zero = z_; v.rdy = r_; v.exp = e_; v.cnt = c_;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] rf[6]  = '{6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h26};
    logic [2:0] rc[6]  = '{3'b110, 3'b000, 3'b001, 3'b011, 3'b111, 3'b100};
    logic [5:0] iop[4] = '{6'h08, 6'h0c, 6'h0d, 6'h0e};
    logic [2:0] ic[4]  = '{3'b010, 3'b000, 3'b001, 3'b100};

    initial begin
        int c = 0;
        // ADD: 0,1,6,7
        add(6'h00, 6'h20, 0, 1, E_FETCH, c); add(6'h00, 6'h20, 0, 1, E_DEC, c);
        add(6'h00, 6'h20, 0, 1, ex(3'b010), c); add(6'h00, 6'h20, 0, 1, E_ALUWB, c); c++;
        // LW with 3 wait cycles in MEMREAD: 8 cycles total
        add(6'h23, 0, 0, 1, E_FETCH, c); add(6'h23, 0, 0, 1, E_DEC, c); add(6'h23, 0, 0, 1, E_MADR, c);
        add(6'h23, 0, 0, 0, E_MRD, c); add(6'h23, 0, 0, 0, E_MRD, c); add(6'h23, 0, 0, 0, E_MRD, c);
        add(6'h23, 0, 0, 1, E_MRD, c); add(6'h23, 0, 0, 1, E_MWB, c); c++;
        // SW with one fetch wait and one write wait
        add(6'h2b, 0, 0, 0, E_FETCHW, c); add(6'h2b, 0, 0, 1, E_FETCH, c); add(6'h2b, 0, 0, 1, E_DEC, c);
        add(6'h2b, 0, 0, 1, E_MADR, c); add(6'h2b, 0, 0, 0, E_MWR, c); add(6'h2b, 0, 0, 1, E_MWR, c); c++;
        // Branches: BEQ/BNE with Zero=1 then Zero=0
        add(6'h04, 0, 1, 1, E_FETCH, c); add(6'h04, 0, 1, 1, E_DEC, c); add(6'h04, 0, 1, 1, br(1), c); c++;
        add(6'h05, 0, 1, 1, E_FETCH, c); add(6'h05, 0, 1, 1, E_DEC, c); add(6'h05, 0, 1, 1, br(0), c); c++;
        add(6'h04, 0, 0, 1, E_FETCH, c); add(6'h04, 0, 0, 1, E_DEC, c); add(6'h04, 0, 0, 1, br(0), c); c++;
        add(6'h05, 0, 0, 1, E_FETCH, c); add(6'h05, 0, 0, 1, E_DEC, c); add(6'h05, 0, 0, 1, br(1), c); c++;
        // J
        add(6'h02, 0, 0, 1, E_FETCH, c); add(6'h02, 0, 0, 1, E_DEC, c); add(6'h02, 0, 0, 1, E_JUMP, c); c++;
        // Remaining R-type functs
        for (int i = 0; i < 6; i++) begin
            add(6'h00, rf[i], 0, 1, E_FETCH, c); add(6'h00, rf[i], 0, 1, E_DEC, c);
            add(6'h00, rf[i], 0, 1, ex(rc[i]), c); add(6'h00, rf[i], 0, 1, E_ALUWB, c); c++;
        end
        // I-type ALU
        for (int i = 0; i < 4; i++) begin
            add(iop[i], 0, 0, 1, E_FETCH, c); add(iop[i], 0, 0, 1, E_DEC, c);
            add(iop[i], 0, 0, 1, im(ic[i]), c); add(iop[i], 0, 0, 1, E_IMMWB, c); c++;
        end
        // Illegal opcode
        add(6'h3f, 0, 0, 1, E_FETCH, c); add(6'h3f, 0, 0, 1, E_DEC, c);
`ifdef ILLEGAL_TRAP_EN
        add(6'h00, 6'h20, 0, 1, E_TRAP, c); add(6'h00, 6'h20, 0, 1, E_TRAP, c);
        add(6'h00, 6'h20, 0, 1, E_TRAP, c);
`else
        // NOP path: flag rides on the next fetch, count unchanged
        add(6'h00, 6'h20, 0, 1, ill(E_FETCH), c); add(6'h00, 6'h20, 0, 1, E_DEC, c);
        add(6'h00, 6'h20, 0, 1, ex(3'b010), c); add(6'h00, 6'h20, 0, 1, E_ALUWB, c); c++;
        // Unknown funct
        add(6'h00, 6'h3f, 0, 1, E_FETCH, c); add(6'h00, 6'h3f, 0, 1, E_DEC, c);
        add(6'h00, 6'h3f, 0, 1, ex(3'b000), c);
        add(6'h02, 0, 0, 1, ill(E_FETCH), c); add(6'h02, 0, 0, 1, E_DEC, c);
        add(6'h02, 0, 0, 1, E_JUMP, c); c++;
        add(6'h02, 0, 0, 0, E_FETCHW, c);
`endif

        // Reset state
        rst_n = 1'b0; op = 6'h00; funct = 6'h20; zero = 1'b0; rdy = 1'b1;
        tick(); tick();
        chk("reset_out", 32'(a1), 32'(E_FETCH));
        chk("reset_cnt", 32'(b1.instr_count), 32'd0);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            op = tv[i].op; funct = tv[i].funct; zero = tv[i].zero; rdy = tv[i].rdy;
            #1;
            chk($sformatf("vec%0d_out", i), 32'(a1), 32'(tv[i].exp));
            chk($sformatf("vec%0d_cnt", i), 32'(b1.instr_count), 32'(tv[i].cnt[15:0]));
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a MEMWRITE wait
        rst_n = 1'b0; rdy = 1'b1; tick();
        chk("rst2_ill", 32'(b1.illegal), 32'd0);
        rst_n = 1'b1; op = 6'h2b; funct = 6'h00;
        tick(); tick(); tick();
        rdy = 1'b0; tick(); tick();
        chk("mw_wait_state", 32'(b1.state), 32'd5);
        chk("mw_wait_strobe", 32'(b1.MemWrite), 32'd1);
        rst_n = 1'b0; rdy = 1'b1; tick();
        chk("mw_abort_state", 32'(b1.state), 32'd0);
        chk("mw_abort_cnt", 32'(b1.instr_count), 32'd0);
        rst_n = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_after%0d", i), 32'({b1.state, b1.MemWrite}), 32'd0);
            tick();
        end

        // Counter wrap on the 4-bit, zero-wait instance (mem_ready held low)
        rst_n = 1'b0; tick();
        rst_n = 1'b1; op = 6'h08; funct = 6'h00; rdy = 1'b0;
        #1;
        chk("zw_irwrite", 32'(b2.IRWrite), 32'd1);
        for (int i = 0; i < 60; i++) tick();
        chk("wrap15_cnt", 32'(b2.instr_count), 32'd15);
        chk("wrap15_state", 32'(b2.state), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("wrap0_cnt", 32'(b2.instr_count), 32'd0);
        chk("u1_stalled", 32'({b1.state, b1.instr_count}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
